aes192_enc_iter: RTL and testbench

AES192_ENC_ITER -- requirements
Module: aes192_enc_iter

---
 rtl/aes192_enc_iter.sv | 114 +++++++++++
 tb/tb_aes192_enc_iter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes192_enc_iter.sv
// Iterative AES-192 encryptor: one round per clock, round keys fetched externally via rk_idx.
// Optional abort input enabled by defining AES192_ENC_ABORT_EN.
module aes192_enc_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key,
`ifdef AES192_ENC_ABORT_EN
  input  logic         abort,
`endif
  output logic [3:0]   rk_idx,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} fsm_t;

  // Byte 0 sits in the MSBs, matching the FIPS-197 column-major byte order.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t                fsm, fsm_nxt;
  logic [3:0]          rnd, rnd_nxt;
  logic [0:15][7:0]    st, st_nxt, sb, sr, mc;
  logic [127:0]        rnd_out, ct_nxt;
  logic                done_nxt, abort_q;

`ifdef AES192_ENC_ABORT_EN
  assign abort_q = abort;
`else
  assign abort_q = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_byte
      assign sb[g] = SBOX[st[g]];
      // row r of column c takes the byte from column (c+r) mod 4
      assign sr[g] = sb[4*(((g/4) + (g%4)) % 4) + (g%4)];
    end
    for (g = 0; g < 4; g++) begin : g_col
      assign mc[4*g+0] = xt(sr[4*g]) ^ xt(sr[4*g+1]) ^ sr[4*g+1] ^ sr[4*g+2] ^ sr[4*g+3];
      assign mc[4*g+1] = sr[4*g] ^ xt(sr[4*g+1]) ^ xt(sr[4*g+2]) ^ sr[4*g+2] ^ sr[4*g+3];
      assign mc[4*g+2] = sr[4*g] ^ sr[4*g+1] ^ xt(sr[4*g+2]) ^ xt(sr[4*g+3]) ^ sr[4*g+3];
      assign mc[4*g+3] = xt(sr[4*g]) ^ sr[4*g] ^ sr[4*g+1] ^ sr[4*g+2] ^ xt(sr[4*g+3]);
    end
  endgenerate

  // Final round drops MixColumns.
  assign rnd_out = ((rnd == 4'd12) ? sr : mc) ^ round_key;
  assign rk_idx  = rnd;
  assign busy    = (fsm == RUN);

  always_comb begin
    fsm_nxt  = fsm;
    rnd_nxt  = rnd;
    st_nxt   = st;
    ct_nxt   = ciphertext;
    done_nxt = 1'b0;
    case (fsm)
      IDLE: if (start) begin
        st_nxt  = plaintext ^ round_key;
        rnd_nxt = 4'd1;
        fsm_nxt = RUN;
      end
      RUN: begin
        if (abort_q) begin
          fsm_nxt = IDLE;
          rnd_nxt = 4'd0;
        end else if (rnd == 4'd12) begin
          ct_nxt   = rnd_out;
          done_nxt = 1'b1;
          fsm_nxt  = IDLE;
          rnd_nxt  = 4'd0;
        end else begin
          st_nxt  = rnd_out;
          rnd_nxt = rnd + 4'd1;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      st         <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      rnd        <= rnd_nxt;
      st         <= st_nxt;
      ciphertext <= ct_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_aes192_enc_iter.sv
// Directed bench for aes192_enc_iter: FIPS-197 C.2, back-to-back, start-while-busy, mid-run reset,
// and abort cases when AES192_ENC_ABORT_EN is defined. Round keys come from a bench key schedule.
module tb_aes192_enc_iter;

  localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk, rst_n, start, busy, done;
  logic [127:0] plaintext, round_key, ciphertext;
  logic [3:0]   rk_idx;
`ifdef AES192_ENC_ABORT_EN
  logic         abort;
`endif

  logic [7:0]   sbm [0:255];
  logic [31:0]  w   [0:51];
  logic [127:0] rk  [0:15];
  logic [127:0] got, ct0;
  int           n_cmp, n_bad;

  aes192_enc_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext), .round_key(round_key),
`ifdef AES192_ENC_ABORT_EN
    .abort(abort),
`endif
    .rk_idx(rk_idx), .ciphertext(ciphertext), .busy(busy), .done(done)
  );

  assign round_key = rk[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in the current (IDLE) cycle; returns in the done cycle.
  task automatic run_block(input logic [127:0] pt, input bit poke, output logic [127:0] res);
    logic [127:0] held;
    held = ciphertext;
    chk("rk_idx_accept", 128'(rk_idx), 128'd0);
    start = 1'b1;
    plaintext = pt;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start = poke && (k == 3 || k == 7);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      chk("rk_idx", 128'(rk_idx), (k < 13) ? 128'(k) : 128'd0);
      chk("busy", 128'(busy), 128'(k < 13));
      chk("done", 128'(done), 128'(k == 13));
      if (k < 13) chk("ct_held", ciphertext, held);
    end
    res = ciphertext;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    plaintext = '0;
`ifdef AES192_ENC_ABORT_EN
    abort = 1'b0;
`endif

    // S-box from GF(2^8) inverse plus affine map
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    begin
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 6; i++) w[i] = KEY[191-32*i -: 32];
      for (int i = 6; i < 52; i++) begin
        t = w[i-1];
        if (i % 6 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]} ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        w[i] = w[i-6] ^ t;
      end
      for (int r = 0; r < 16; r++)
        rk[r] = (r < 13) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
    end

    // reset state
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.2, then back-to-back pt=0 started in the done cycle
    run_block(PT, 1'b0, got);
    chk("c2_ct", got, CT);
    run_block(128'd0, 1'b0, ct0);
    tick();
    chk("b2b_done_drop", 128'(done), 128'd0);
    chk("b2b_ct_hold", ciphertext, ct0);

    // start pulses while busy are ignored
    run_block(PT, 1'b1, got);
    chk("busy_start_ct", got, CT);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_start_idle", 128'(busy), 128'd0);
      chk("busy_start_nodone", 128'(done), 128'd0);
    end

    // reset in the middle of a run
    start = 1'b1;
    plaintext = PT;
    for (int k = 0; k < 6; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_ct", ciphertext, 128'd0);
    chk("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_nodone", 128'(done), 128'd0);
    end
    run_block(PT, 1'b0, got);
    chk("post_rst_c2", got, CT);
    tick();
    run_block(128'd0, 1'b0, got);
    chk("pt0_repeat", got, ct0);
    tick();

`ifdef AES192_ENC_ABORT_EN
    // abort at rnd=5
    start = 1'b1;
    plaintext = PT;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort5_busy", 128'(busy), 128'd0);
    chk("abort5_done", 128'(done), 128'd0);
    chk("abort5_ct", ciphertext, ct0);
    chk("abort5_rk_idx", 128'(rk_idx), 128'd0);
    // abort coinciding with the final round
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort12_busy", 128'(busy), 128'd0);
    chk("abort12_done", 128'(done), 128'd0);
    chk("abort12_ct", ciphertext, ct0);
    tick();
    chk("abort12_late_done", 128'(done), 128'd0);
    run_block(PT, 1'b0, got);
    chk("post_abort_c2", got, CT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
